// File: rtl/speed_ctrl_pkg.sv
// Shared types and constants for the motor speed measurement sequencer.
package speed_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_STALL = 2'd3
  } speed_ctrl_state_t;

  localparam int unsigned MIN_WINDOW_CYCLES = 2;

endpackage

// File: rtl/pulse_timebase.sv
// Free-running window time base: one-cycle registered pulse every period cycles while enabled.
module pulse_timebase
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_pulse
);

  localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(MIN_WINDOW_CYCLES);

  logic [WIDTH-1:0] tb;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_clamped;
  logic             wrap;

  assign period_clamped = (i_period < MIN_PERIOD) ? MIN_PERIOD : i_period;
  assign wrap           = (tb == (period_q - WIDTH'(1)));

  // The period is only picked up while idle or at a wrap, so a change mid-window
  // never shortens or stretches the window already in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tb       <= '0;
      period_q <= MIN_PERIOD;
      o_pulse  <= 1'b0;
    end else if (!i_enable) begin
      tb       <= '0;
      period_q <= period_clamped;
      o_pulse  <= 1'b0;
    end else if (wrap) begin
      tb       <= '0;
      period_q <= period_clamped;
      o_pulse  <= 1'b1;
    end else begin
      tb       <= tb + WIDTH'(1);
      o_pulse  <= 1'b0;
    end
  end

endmodule

// File: rtl/speed_meter_ctrl.sv
// Speed measurement sequencer: window time base, counter force-reset/unlock
// handshake and stall detection from consecutive empty windows.
//
// state   | meaning
// S_IDLE  | measurement disabled, counter held in reset
// S_ARM   | counter unlocked, waiting for first window boundary
// S_RUN   | measuring; empty windows counted towards stall
// S_STALL | rotor stalled, counter held until cleared
module speed_meter_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned STALL_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_spd_evt,
  input  logic [CNT_WIDTH-1:0]   i_window_cycles,
  input  logic [STALL_WIDTH-1:0] i_stall_windows,
  input  logic                   i_stall_clr,
  output logic                   o_time_trigger,
  output logic                   o_force_reset,
  output logic                   o_unlock,
  output logic                   o_stall,
  output logic [1:0]             o_state
);

  speed_ctrl_state_t      state;
  logic                   evt_seen;
  logic [STALL_WIDTH-1:0] miss;
  logic [STALL_WIDTH-1:0] miss_next;
  logic                   window_hit;
  logic                   stall_hit;

  pulse_timebase #(
    .WIDTH (CNT_WIDTH)
  ) u_timebase (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_period (i_window_cycles),
    .o_pulse  (o_time_trigger)
  );

  // An event coincident with the trigger still counts for the window being closed.
  assign window_hit = evt_seen | i_spd_evt;
  assign miss_next  = window_hit ? '0 :
                      (&miss)    ? miss : miss + STALL_WIDTH'(1);
  assign stall_hit  = (i_stall_windows != '0) && (miss_next >= i_stall_windows);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_seen <= 1'b0;
    end else if (!i_enable || o_time_trigger) begin
      evt_seen <= 1'b0;
    end else if (i_spd_evt) begin
      evt_seen <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      miss          <= '0;
      o_force_reset <= 1'b1;
      o_unlock      <= 1'b0;
      o_stall       <= 1'b0;
    end else if (!i_enable) begin
      state         <= S_IDLE;
      miss          <= '0;
      o_force_reset <= 1'b1;
      o_unlock      <= 1'b0;
      o_stall       <= 1'b0;
    end else begin
      o_unlock <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state         <= S_ARM;
          o_force_reset <= 1'b0;
          o_unlock      <= 1'b1;
        end
        S_ARM: begin
          if (o_time_trigger) begin
            state <= S_RUN;
            miss  <= '0;
          end
        end
        S_RUN: begin
          if (o_time_trigger) begin
            miss <= miss_next;
            if (stall_hit) begin
              state         <= S_STALL;
              o_force_reset <= 1'b1;
              o_stall       <= 1'b1;
            end
          end
        end
        S_STALL: begin
          if (i_stall_clr) begin
            state         <= S_ARM;
            o_force_reset <= 1'b0;
            o_unlock      <= 1'b1;
            o_stall       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_speed_meter_ctrl.sv
// Self-checking bench for speed_meter_ctrl: window-length vector table plus
// hand-written stall, event-accounting, enable-drop and async-reset sequences.
module tb_speed_meter_ctrl;
  import speed_ctrl_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_spd_evt = 1'b0;
  logic        i_stall_clr = 1'b0;
  logic [23:0] i_window_cycles = 24'd10;
  logic [7:0]  i_stall_windows = 8'd0;
  logic        o_time_trigger;
  logic        o_force_reset;
  logic        o_unlock;
  logic        o_stall;
  logic [1:0]  o_state;

  always #5 i_clk = ~i_clk;

  speed_meter_ctrl #(
    .CNT_WIDTH   (24),
    .STALL_WIDTH (8)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_enable        (i_enable),
    .i_spd_evt       (i_spd_evt),
    .i_window_cycles (i_window_cycles),
    .i_stall_windows (i_stall_windows),
    .i_stall_clr     (i_stall_clr),
    .o_time_trigger  (o_time_trigger),
    .o_force_reset   (o_force_reset),
    .o_unlock        (o_unlock),
    .o_stall         (o_stall),
    .o_state         (o_state)
  );

  typedef struct packed {
    logic       trig;
    logic       frc;
    logic       unl;
    logic       stl;
    logic [1:0] st;
  } obs_t;

  typedef struct {
    int win;
    int period;
    int ncyc;
  } win_vec_t;

  obs_t     sb_q[$];
  win_vec_t vecs[6];
  int       n_checks = 0;
  int       n_fail = 0;

  function automatic obs_t mk(input logic trig, input logic frc, input logic unl,
                              input logic stl, input logic [1:0] st);
    return {trig, frc, unl, stl, st};
  endfunction

  function automatic obs_t sample();
    return {o_time_trigger, o_force_reset, o_unlock, o_stall, o_state};
  endfunction

  task automatic cmp(input string name, input int c, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got trig/frc/unl/stl/state=%b/%b/%b/%b/%0d, expected %b/%b/%b/%b/%0d",
               name, c, got.trig, got.frc, got.unl, got.stl, got.st,
               exp.trig, exp.frc, exp.unl, exp.stl, exp.st);
    end
  endtask

  // Expected value queued when the stimulus for cycle c is driven, popped once the DUT has produced it.
  task automatic cyc(input string name, input int c, input obs_t e);
    obs_t exp;
    sb_q.push_back(e);
    @(negedge i_clk);
    exp = sb_q.pop_front();
    cmp(name, c, sample(), exp);
  endtask

  task automatic do_reset(input logic [23:0] w, input logic [7:0] n);
    i_enable        = 1'b0;
    i_spd_evt       = 1'b0;
    i_stall_clr     = 1'b0;
    i_window_cycles = w;
    i_stall_windows = n;
    i_rst_n         = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{'{0, 2, 8}, '{1, 2, 8}, '{2, 2, 8}, '{3, 3, 10}, '{7, 7, 16}, '{10, 10, 35}};

    #2 i_rst_n = 1'b0;
    #1 cmp("reset_values", 0, sample(), mk(1'b0, 1'b1, 1'b0, 1'b0, S_IDLE));

    // Window length table, stall detection disabled, no speed events.
    foreach (vecs[i]) begin
      do_reset(24'(vecs[i].win), 8'd0);
      i_enable = 1'b1;
      for (int c = 1; c <= vecs[i].ncyc; c++) begin
        cyc($sformatf("win%0d", vecs[i].win), c,
            mk((c % vecs[i].period) == 0, 1'b0, c == 1, 1'b0,
               (c <= vecs[i].period) ? S_ARM : S_RUN));
      end
    end

    // Stall after three empty windows, re-arm, ignored clear in RUN, then IDLE wins over clear.
    do_reset(24'd4, 8'd3);
    i_enable = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      cyc("stall3", c, mk((c % 4) == 0, c >= 17, c == 1, c >= 17,
                          (c <= 4) ? S_ARM : (c <= 16) ? S_RUN : S_STALL));
    end
    i_stall_clr = 1'b1;
    cyc("stall_clr", 23, mk(1'b0, 1'b0, 1'b1, 1'b0, S_ARM));
    i_stall_clr = 1'b0;
    for (int c = 24; c <= 37; c++) begin
      i_stall_clr = (c == 27);
      cyc("rearm", c, mk((c % 4) == 0, c >= 37, 1'b0, c >= 37,
                         (c == 24) ? S_ARM : (c <= 36) ? S_RUN : S_STALL));
    end
    i_stall_clr = 1'b1;
    i_enable    = 1'b0;
    cyc("clr_vs_disable", 38, mk(1'b0, 1'b1, 1'b0, 1'b0, S_IDLE));
    i_stall_clr = 1'b0;
    cyc("idle_hold", 39, mk(1'b0, 1'b1, 1'b0, 1'b0, S_IDLE));

    // Events only coincident with triggers keep miss at 0 even with threshold 1.
    do_reset(24'd5, 8'd1);
    i_enable = 1'b1;
    for (int c = 1; c <= 47; c++) begin
      i_spd_evt = (c > 1) && (((c - 1) % 5) == 0) && ((c - 1) <= 40);
      cyc("coincident_evt", c, mk((c % 5) == 0, c >= 46, c == 1, c >= 46,
                                  (c <= 5) ? S_ARM : (c <= 45) ? S_RUN : S_STALL));
    end
    i_spd_evt = 1'b0;
    #2 i_rst_n = 1'b0;
    #1 cmp("async_reset_in_stall", 48, sample(), mk(1'b0, 1'b1, 1'b0, 1'b0, S_IDLE));
    @(negedge i_clk);
    cmp("reset_held", 48, sample(), mk(1'b0, 1'b1, 1'b0, 1'b0, S_IDLE));

    // Enable dropped mid-window in RUN, re-raised five cycles later.
    do_reset(24'd6, 8'd0);
    i_enable = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      cyc("pre_drop", c, mk((c % 6) == 0, 1'b0, c == 1, 1'b0, (c <= 6) ? S_ARM : S_RUN));
    end
    i_enable = 1'b0;
    for (int c = 16; c <= 20; c++) begin
      cyc("dropped", c, mk(1'b0, 1'b1, 1'b0, 1'b0, S_IDLE));
    end
    i_enable = 1'b1;
    for (int c = 21; c <= 34; c++) begin
      cyc("re_enable", c, mk(((c - 20) % 6) == 0, 1'b0, c == 21, 1'b0,
                             ((c - 20) <= 6) ? S_ARM : S_RUN));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
